// File: rtl/calc_entry_sequencer_if.sv
// Bundle of the key-event, ALU-handshake and display signals of the
// calculator entry sequencer. The sequencer uses the slave view; the keypad/ALU side uses the master view.
interface calc_entry_sequencer_if #(
   parameter int unsigned N = 16
);
   logic         key_valid;
   logic [3:0]   key_code;
   logic [1:0]   key_class;
   logic         alu_done;
   logic [N-1:0] alu_result;
   logic         alu_err;
   logic         alu_start;
   logic [N-1:0] operand_a;
   logic [N-1:0] operand_b;
   logic [1:0]   alu_op;
   logic [N-1:0] display_value;
   logic         busy;
   logic         err;
   logic [2:0]   state_dbg;

   modport master (
      output key_valid, key_code, key_class, alu_done, alu_result, alu_err,
      input  alu_start, operand_a, operand_b, alu_op, display_value, busy, err, state_dbg
   );

   modport slave (
      input  key_valid, key_code, key_class, alu_done, alu_result, alu_err,
      output alu_start, operand_a, operand_b, alu_op, display_value, busy, err, state_dbg
   );
endinterface

// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: turns keypad events into decimal operands A/B,
// latches the operator, launches the ALU and holds the result for display.
// All outputs come straight from registers.
module calc_entry_sequencer #(
   parameter int unsigned N = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   calc_entry_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ENTER_A  = 3'd0,
      ENTER_OP = 3'd1,
      ENTER_B  = 3'd2,
      WAIT_ALU = 3'd3,
      SHOW_RES = 3'd4,
      ERROR    = 3'd5
   } state_t;

   localparam logic [1:0] CLS_DIGIT = 2'b00;
   localparam logic [1:0] CLS_OP    = 2'b01;
   localparam logic [1:0] CLS_CLEAR = 2'b10;
   localparam logic [1:0] CLS_EQ    = 2'b11;

   // cur*10 + digit in N+4 bits, so any overflow shows up in the top nibble
   function automatic logic [N+3:0] dec_shift(input logic [N-1:0] cur, input logic [3:0] digit);
      logic [N+3:0] wide;
      wide = {4'd0, cur};
      return (wide << 3) + (wide << 1) + {{N{1'b0}}, digit};
   endfunction

   state_t       state_r;
   logic [N-1:0] a_r;
   logic [N-1:0] b_r;
   logic [1:0]   op_r;
   logic [N-1:0] disp_r;
   logic         start_r;
   logic         busy_r;
   logic         err_r;
   logic         has_digit_r;
   logic         abort_pending_r;

   logic         key_digit_s;
   logic         key_op_s;
   logic         key_clr_s;
   logic         key_eq_s;
   logic [N+3:0] acc_a_s;
   logic [N+3:0] acc_b_s;
   logic         ovf_a_s;
   logic         ovf_b_s;
   logic [1:0]   op_code_s;
   logic [N-1:0] digit_ext_s;

   // Decode the key event and precompute both candidate accumulations
   always_comb begin
      key_digit_s = 1'b0;
      key_op_s    = 1'b0;
      key_clr_s   = 1'b0;
      key_eq_s    = 1'b0;
      if (bus.key_valid) begin
         case (bus.key_class)
            CLS_DIGIT: key_digit_s = 1'b1;
            CLS_OP:    key_op_s    = 1'b1;
            CLS_CLEAR: key_clr_s   = 1'b1;
            CLS_EQ:    key_eq_s    = 1'b1;
            default:   key_digit_s = 1'b0;
         endcase
      end else begin
         key_digit_s = 1'b0;
      end
      acc_a_s     = dec_shift(a_r, bus.key_code);
      acc_b_s     = dec_shift(b_r, bus.key_code);
      ovf_a_s     = |acc_a_s[N+3:N];
      ovf_b_s     = |acc_b_s[N+3:N];
      // (code - 10) mod 4 only depends on the low two code bits
      op_code_s   = bus.key_code[1:0] - 2'd2;
      digit_ext_s = {{(N-4){1'b0}}, bus.key_code};
   end

   // Main sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ENTER_A;
         a_r             <= {N{1'b0}};
         b_r             <= {N{1'b0}};
         op_r            <= 2'd0;
         disp_r          <= {N{1'b0}};
         start_r         <= 1'b0;
         busy_r          <= 1'b0;
         err_r           <= 1'b0;
         has_digit_r     <= 1'b0;
         abort_pending_r <= 1'b0;
      end else begin
         start_r <= 1'b0;
         if (state_r == WAIT_ALU) begin
            if (bus.alu_done) begin
               busy_r <= 1'b0;
               if (abort_pending_r || key_clr_s) begin
                  // aborted operation: drop the result and start over
                  state_r         <= ENTER_A;
                  a_r             <= {N{1'b0}};
                  b_r             <= {N{1'b0}};
                  op_r            <= 2'd0;
                  disp_r          <= {N{1'b0}};
                  err_r           <= 1'b0;
                  has_digit_r     <= 1'b0;
                  abort_pending_r <= 1'b0;
               end else if (bus.alu_err) begin
                  err_r   <= 1'b1;
                  disp_r  <= {N{1'b0}};
                  state_r <= ERROR;
               end else begin
                  disp_r  <= bus.alu_result;
                  a_r     <= bus.alu_result;
                  state_r <= SHOW_RES;
               end
            end else if (key_clr_s) begin
               abort_pending_r <= 1'b1;
            end
         end else if (key_clr_s) begin
            state_r         <= ENTER_A;
            a_r             <= {N{1'b0}};
            b_r             <= {N{1'b0}};
            op_r            <= 2'd0;
            disp_r          <= {N{1'b0}};
            err_r           <= 1'b0;
            has_digit_r     <= 1'b0;
            abort_pending_r <= 1'b0;
            busy_r          <= 1'b0;
         end else begin
            case (state_r)
               ENTER_A: begin
                  if (key_digit_s) begin
                     if (ovf_a_s) begin
                        err_r   <= 1'b1;
                        state_r <= ERROR;
                     end else begin
                        a_r         <= acc_a_s[N-1:0];
                        disp_r      <= acc_a_s[N-1:0];
                        has_digit_r <= 1'b1;
                     end
                  end else if (key_op_s) begin
                     op_r        <= op_code_s;
                     b_r         <= {N{1'b0}};
                     has_digit_r <= 1'b0;
                     state_r     <= ENTER_B;
                  end
               end
               ENTER_OP: begin
                  state_r <= ENTER_B;
               end
               ENTER_B: begin
                  if (key_digit_s) begin
                     if (ovf_b_s) begin
                        err_r   <= 1'b1;
                        state_r <= ERROR;
                     end else begin
                        b_r         <= acc_b_s[N-1:0];
                        disp_r      <= acc_b_s[N-1:0];
                        has_digit_r <= 1'b1;
                     end
                  end else if (key_op_s && !has_digit_r) begin
                     op_r <= op_code_s;
                  end else if (key_eq_s && has_digit_r) begin
                     start_r         <= 1'b1;
                     busy_r          <= 1'b1;
                     abort_pending_r <= 1'b0;
                     state_r         <= WAIT_ALU;
                  end
               end
               SHOW_RES: begin
                  if (key_digit_s) begin
                     // a fresh number starts a new calculation
                     a_r         <= digit_ext_s;
                     b_r         <= {N{1'b0}};
                     disp_r      <= digit_ext_s;
                     has_digit_r <= 1'b1;
                     state_r     <= ENTER_A;
                  end else if (key_op_s) begin
                     // chain: the result stays in A as the left operand
                     op_r        <= op_code_s;
                     b_r         <= {N{1'b0}};
                     has_digit_r <= 1'b0;
                     state_r     <= ENTER_OP;
                  end
               end
               ERROR: begin
                  state_r <= ERROR;
               end
               default: begin
                  state_r <= ENTER_A;
               end
            endcase
         end
      end
   end

   assign bus.alu_start     = start_r;
   assign bus.operand_a     = a_r;
   assign bus.operand_b     = b_r;
   assign bus.alu_op        = op_r;
   assign bus.display_value = disp_r;
   assign bus.busy          = busy_r;
   assign bus.err           = err_r;
   assign bus.state_dbg     = state_r;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Self-checking bench for calc_entry_sequencer: a fixed vector table, hand
// sequences for the corner cases and a randomized run against a reference model.
module tb_calc_entry_sequencer;
   localparam int N    = 16;
   localparam int MAXV = 65535;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   calc_entry_sequencer_if #(.N(N)) bus();

   calc_entry_sequencer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // reference model: mode uses the spec's state numbers, values are plain ints
   int m_st, m_a, m_b, m_op, m_disp, m_err, m_hd, m_abort, m_busy, m_start;

   typedef struct {
      logic        kv;
      logic [3:0]  code;
      logic [1:0]  cls;
      logic        done;
      logic [15:0] res;
      logic        aerr;
      int e_a, e_b, e_op, e_disp, e_st, e_start, e_busy, e_err;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic kv, input int code, input int cls, input logic done,
                               input int res, input int a, input int b, input int op,
                               input int disp, input int st, input int start, input int busy);
      vec_t v;
      v.kv = kv; v.code = code[3:0]; v.cls = cls[1:0]; v.done = done; v.res = res[15:0];
      v.aerr = 1'b0; v.e_a = a; v.e_b = b; v.e_op = op; v.e_disp = disp; v.e_st = st;
      v.e_start = start; v.e_busy = busy; v.e_err = 0;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic kv, input int code, input int cls, input logic done,
                        input int res, input logic aerr);
      @(negedge clk);
      bus.key_valid  = kv;
      bus.key_code   = code[3:0];
      bus.key_class  = cls[1:0];
      bus.alu_done   = done;
      bus.alu_result = res[15:0];
      bus.alu_err    = aerr;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_err = 0;
      m_hd = 0; m_abort = 0; m_busy = 0; m_start = 0;
   endtask

   // one clock edge of the calculator's behaviour, in arithmetic terms
   task automatic model_edge(input logic kv, input int code, input int cls, input logic done,
                             input int res, input logic aerr);
      bit clr, dig, op, eq;
      int nxt;
      clr = kv && cls == 2; dig = kv && cls == 0; op = kv && cls == 1; eq = kv && cls == 3;
      m_start = 0;
      if (m_st == 3) begin
         if (done) begin
            m_busy = 0;
            if (m_abort || clr) model_clear();
            else if (aerr) begin m_err = 1; m_st = 5; m_disp = 0; end
            else begin m_disp = res; m_a = res; m_st = 4; end
         end else if (clr) m_abort = 1;
      end else if (clr) begin
         model_clear();
      end else if (m_st == 0 && dig) begin
         nxt = m_a * 10 + code;
         if (nxt > MAXV) begin m_err = 1; m_st = 5; end
         else begin m_a = nxt; m_disp = nxt; m_hd = 1; end
      end else if (m_st == 0 && op) begin
         m_op = (code - 10) & 3; m_b = 0; m_hd = 0; m_st = 2;
      end else if (m_st == 1) begin
         m_st = 2;
      end else if (m_st == 2 && dig) begin
         nxt = m_b * 10 + code;
         if (nxt > MAXV) begin m_err = 1; m_st = 5; end
         else begin m_b = nxt; m_disp = nxt; m_hd = 1; end
      end else if (m_st == 2 && op && m_hd == 0) begin
         m_op = (code - 10) & 3;
      end else if (m_st == 2 && eq && m_hd == 1) begin
         m_start = 1; m_busy = 1; m_abort = 0; m_st = 3;
      end else if (m_st == 4 && dig) begin
         m_a = code; m_b = 0; m_disp = code; m_hd = 1; m_st = 0;
      end else if (m_st == 4 && op) begin
         m_op = (code - 10) & 3; m_b = 0; m_hd = 0; m_st = 1;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".operand_a"},     bus.operand_a,     m_a);
      chk({tag, ".operand_b"},     bus.operand_b,     m_b);
      chk({tag, ".alu_op"},        bus.alu_op,        m_op);
      chk({tag, ".display_value"}, bus.display_value, m_disp);
      chk({tag, ".state_dbg"},     bus.state_dbg,     m_st);
      chk({tag, ".alu_start"},     bus.alu_start,     m_start);
      chk({tag, ".busy"},          bus.busy,          m_busy);
      chk({tag, ".err"},           bus.err,           m_err);
   endtask

   task automatic step(input string tag, input logic kv, input int code, input int cls,
                       input logic done, input int res, input logic aerr);
      drive(kv, code, cls, done, res, aerr);
      model_edge(kv, code, cls, done, res, aerr);
      check_model(tag);
   endtask

   task automatic key(input string tag, input int code, input int cls);
      step(tag, 1'b1, code, cls, 1'b0, 0, 1'b0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".operand_a"},     bus.operand_a,     0);
      chk({tag, ".operand_b"},     bus.operand_b,     0);
      chk({tag, ".alu_op"},        bus.alu_op,        0);
      chk({tag, ".display_value"}, bus.display_value, 0);
      chk({tag, ".state_dbg"},     bus.state_dbg,     0);
      chk({tag, ".alu_start"},     bus.alu_start,     0);
      chk({tag, ".busy"},          bus.busy,          0);
      chk({tag, ".err"},           bus.err,           0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int pend, cnt, r, code, cls;
      logic kv, done, aerr;
      int res;

      bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.key_class = 2'd0;
      bus.alu_done = 1'b0; bus.alu_result = 16'd0; bus.alu_err = 1'b0;
      rst_n = 1'b0;
      #12;
      check_all_zero("por");
      rst_n = 1'b1;

      // ---- table: 1234 + 5, then chain 9 op2 3 ----
      //            kv   code cls done res   A     B  op disp st start busy
      tbl[0]  = mk(1'b1, 1,  0, 1'b0, 0,    1,    0, 0, 1,    0, 0, 0);
      tbl[1]  = mk(1'b1, 2,  0, 1'b0, 0,    12,   0, 0, 12,   0, 0, 0);
      tbl[2]  = mk(1'b1, 3,  0, 1'b0, 0,    123,  0, 0, 123,  0, 0, 0);
      tbl[3]  = mk(1'b1, 4,  0, 1'b0, 0,    1234, 0, 0, 1234, 0, 0, 0);
      tbl[4]  = mk(1'b1, 10, 1, 1'b0, 0,    1234, 0, 0, 1234, 2, 0, 0);
      tbl[5]  = mk(1'b1, 5,  0, 1'b0, 0,    1234, 5, 0, 5,    2, 0, 0);
      tbl[6]  = mk(1'b1, 15, 3, 1'b0, 0,    1234, 5, 0, 5,    3, 1, 1);
      tbl[7]  = mk(1'b0, 0,  0, 1'b0, 0,    1234, 5, 0, 5,    3, 0, 1);
      tbl[8]  = mk(1'b0, 0,  0, 1'b1, 9,    9,    5, 0, 9,    4, 0, 0);
      tbl[9]  = mk(1'b1, 12, 1, 1'b0, 0,    9,    0, 2, 9,    1, 0, 0);
      tbl[10] = mk(1'b0, 0,  0, 1'b0, 0,    9,    0, 2, 9,    2, 0, 0);
      tbl[11] = mk(1'b1, 3,  0, 1'b0, 0,    9,    3, 2, 3,    2, 0, 0);
      tbl[12] = mk(1'b1, 15, 3, 1'b0, 0,    9,    3, 2, 3,    3, 1, 1);
      tbl[13] = mk(1'b0, 0,  0, 1'b1, 27,   27,   3, 2, 27,   4, 0, 0);
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].kv, tbl[i].code, tbl[i].cls, tbl[i].done, tbl[i].res, tbl[i].aerr);
         chk($sformatf("tbl%0d.operand_a", i),     bus.operand_a,     tbl[i].e_a);
         chk($sformatf("tbl%0d.operand_b", i),     bus.operand_b,     tbl[i].e_b);
         chk($sformatf("tbl%0d.alu_op", i),        bus.alu_op,        tbl[i].e_op);
         chk($sformatf("tbl%0d.display_value", i), bus.display_value, tbl[i].e_disp);
         chk($sformatf("tbl%0d.state_dbg", i),     bus.state_dbg,     tbl[i].e_st);
         chk($sformatf("tbl%0d.alu_start", i),     bus.alu_start,     tbl[i].e_start);
         chk($sformatf("tbl%0d.busy", i),          bus.busy,          tbl[i].e_busy);
         chk($sformatf("tbl%0d.err", i),           bus.err,           tbl[i].e_err);
      end

      // ---- overflow at 2^16-1 ----
      do_reset();
      key("ovf_d6", 6, 0); key("ovf_d5", 5, 0); key("ovf_d5b", 5, 0);
      key("ovf_d3", 3, 0); key("ovf_d5c", 5, 0);
      chk("max_a", bus.operand_a, 65535);
      key("ovf_d0", 0, 0);
      chk("ovf_a_kept", bus.operand_a, 65535);
      chk("ovf_err", bus.err, 1);
      chk("ovf_state", bus.state_dbg, 5);
      key("err_d7", 7, 0);
      key("err_eq", 15, 3);
      chk("err_ignores_keys", bus.operand_a, 65535);
      key("err_clr", 14, 2);
      chk("clr_a", bus.operand_a, 0);
      chk("clr_err", bus.err, 0);
      chk("clr_state", bus.state_dbg, 0);

      // ---- abort while busy ----
      key("ab_d8", 8, 0); key("ab_op", 10, 1); key("ab_d2", 2, 0); key("ab_eq", 15, 3);
      key("ab_clr", 14, 2);
      idle("ab_i1"); key("ab_eq2", 15, 3); idle("ab_i2");
      step("ab_done", 1'b0, 0, 0, 1'b1, 42, 1'b0);
      chk("abort_disp", bus.display_value, 0);
      chk("abort_state", bus.state_dbg, 0);

      // ---- ALU error ----
      key("ae_d1", 1, 0); key("ae_op", 11, 1); key("ae_d0", 0, 0); key("ae_eq", 15, 3);
      idle("ae_i1");
      step("ae_done", 1'b0, 0, 0, 1'b1, 5, 1'b1);
      chk("alu_err_flag", bus.err, 1);
      chk("alu_err_state", bus.state_dbg, 5);
      chk("alu_err_disp", bus.display_value, 0);
      key("ae_clr", 14, 2);

      // ---- equals without a B digit, operator replacement, stray done ----
      step("stray_done", 1'b0, 0, 0, 1'b1, 77, 1'b0);
      key("nd_op10", 10, 1); key("nd_eq", 15, 3);
      chk("nd_no_start", bus.alu_start, 0);
      key("nd_op11", 11, 1);
      chk("op_replaced", bus.alu_op, 1);
      key("nd_d4", 4, 0); key("nd_op13", 13, 1);
      chk("op_kept_after_digit", bus.alu_op, 1);

      // ---- key colliding with done: digit dropped, then clear as abort ----
      key("co_eq", 15, 3);
      step("co_done_dig", 1'b1, 7, 0, 1'b1, 300, 1'b0);
      key("co_op", 12, 1); idle("co_i"); key("co_d1", 1, 0); key("co_eq2", 15, 3);
      step("co_done_clr", 1'b1, 14, 2, 1'b1, 500, 1'b0);

      // ---- asynchronous reset in WAIT_ALU ----
      key("ar_d3", 3, 0); key("ar_op", 10, 1); key("ar_d3b", 3, 0); key("ar_eq", 15, 3);
      chk("ar_busy", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // ---- randomized run with a behavioural ALU ----
      pend = 0; cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         kv = ($urandom_range(0, 99) < 40);
         r  = $urandom_range(0, 99);
         if (r < 50)      begin cls = 0; code = $urandom_range(0, 9); end
         else if (r < 68) begin cls = 1; code = $urandom_range(10, 13); end
         else if (r < 75) begin cls = 2; code = 14; end
         else             begin cls = 3; code = 15; end
         done = (pend != 0) && (cnt == 0);
         res  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 999);
         aerr = done && ($urandom_range(0, 7) == 0);
         step("rnd", kv, code, cls, done, res, aerr);
         if (done) pend = 0;
         else if (pend != 0) cnt--;
         if (m_start != 0) begin
            chk("rnd_single_start", pend, 0);
            pend = 1;
            cnt  = $urandom_range(0, 5);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/calc_entry_sequencer.md
Name: calc_entry_sequencer

Overview:
- Sits between the keypad scanner and the N-bit ALU.
- Consumes one-cycle key events (4-bit key code plus 2-bit key class) and builds decimal operands A and B.
- Latches the operator, launches the ALU with a start/done handshake, and holds the result for display.
- Supports clear, chained operations and ALU error reporting.

Parameters:
- N, 16, operand/result width in bits (unsigned).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  one-cycle pulse, a new key press
- key_code  input  4  key value, sampled when key_valid=1; 0-9 digit, 10-13 operator, 14 clear, 15 equals
- key_class  input  2  00 digit, 01 operator, 10 clear, 11 equals; sampled with key_code
- alu_done  input  1  one-cycle pulse, ALU finished
- alu_result  input  N  ALU result, valid when alu_done=1
- alu_err  input  1  ALU error (overflow/divide-by-zero), valid when alu_done=1
- alu_start  output  1  one-cycle pulse launching the ALU
- operand_a  output  N  latched operand A
- operand_b  output  N  latched operand B
- alu_op  output  2  operator, equal to key_code-10 of the accepted operator key
- display_value  output  N  value to show
- busy  output  1  high in WAIT_ALU
- err  output  1  sticky error flag, cleared only by clear key or reset
- state_dbg  output  3  current state encoding

Behaviour:
- Reset (async, rst_n=0): state=ENTER_A; operand_a, operand_b, display_value, alu_op = 0; alu_start, busy, err = 0; has_digit=0; abort_pending=0.
- key_class is authoritative. key_code is used only for the digit value and for alu_op.
- States: ENTER_A=0, ENTER_OP=1, ENTER_B=2, WAIT_ALU=3, SHOW_RES=4, ERROR=5.
- Digit accumulation:
  - next = cur*10 + digit, computed in N+4 bits as (cur<<3)+(cur<<1)+digit.
  - If next > 2^N-1: value unchanged, err set, state goes to ERROR.
  - Otherwise the value updates and has_digit=1.
- ENTER_A:
  - digit: accumulate into A; display_value=A.
  - operator: alu_op<=code-10, B<=0, has_digit<=0, go ENTER_B. display_value keeps A.
  - equals: ignored.
- ENTER_B:
  - digit: accumulate into B; display_value=B.
  - operator with has_digit=0: replaces alu_op.
  - operator with has_digit=1: ignored.
  - equals with has_digit=1: alu_start=1 for exactly one cycle (registered, asserted the cycle after key_valid); go WAIT_ALU; busy=1.
  - equals with has_digit=0: ignored.
- ENTER_OP: transient entry state used only when chaining from SHOW_RES. It has no key-driven exit and falls through to ENTER_B on the next cycle.
- WAIT_ALU:
  - All digit, operator and equals keys are ignored.
  - Clear sets abort_pending.
  - On alu_done with abort_pending=1: discard the result and go ENTER_A with all cleared.
  - On alu_done with alu_err=1: err=1, go ERROR, display_value=0.
  - Otherwise: display_value<=alu_result, operand_a<=alu_result, go SHOW_RES.
  - busy drops in the same edge as the state exit.
- SHOW_RES:
  - digit: A<=digit, B<=0, go ENTER_A.
  - operator: keep A=result, set alu_op, B<=0, has_digit<=0, go ENTER_OP.
  - equals: ignored.
- ERROR: every key except clear is ignored.
- Clear, in any state except WAIT_ALU: same-edge return to ENTER_A; A, B, alu_op, display_value, has_digit, err all cleared.
- alu_done outside WAIT_ALU is ignored.
- alu_start is never asserted while busy=1. At most one start per completed done.
- key_valid coinciding with alu_done in WAIT_ALU: the alu_done is processed and the key is dropped, except clear, which is honoured as abort.
- Key event latency: state and data update on the edge where key_valid=1; outputs are visible the next cycle.

Test Plan:
- Reset then keys 1,2,3 → operand_a=123, display_value=123, state_dbg=0; each update visible one cycle after its key_valid.
- Keys 4, op code 10, 5, equals → alu_op=0, operand_b=5, single-cycle alu_start, busy=1. Then alu_done with alu_result=9 → display_value=9, operand_a=9, state_dbg=4, busy=0.
- From SHOW_RES (result 9): op 12, 3, equals → alu_op=2, operand_a=9, operand_b=3, alu_start pulses once.
- N=16: enter 6,5,5,3,5 → A=65535. Digit 0 → A stays 65535, err=1, state ERROR. Digit 7 → ignored. Clear → A=0, err=0, state_dbg=0.
- Equals then clear while busy → no new alu_start. Later alu_done with result 42 → display_value=0, state ENTER_A. Separate run with alu_done and alu_err=1 → err=1, state ERROR, display_value=0.
- Boundary runs:
  - Equals in ENTER_B with no digit → no alu_start.
  - Op 10 then op 11 before any B digit → alu_op=1.
  - rst_n asserted mid-WAIT_ALU → all outputs zero immediately, asynchronously.
